// File: rtl/picorv32_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_uart_pkg
// Description : Shared constants and types for the picorv32 UART transmitter:
//               register offsets, STATUS bit positions, serialiser states.
// Revision    : 1.0 - initial release
// ============================================================================
package picorv32_uart_pkg;

    // Register offsets inside the 16-byte window
    localparam logic [3:0] UART_DATA   = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_DIV    = 4'h8;

    // STATUS register bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_IDLE    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_LVL_LSB = 4;

    // Smallest divisor that still gives a countdown of at least one cycle
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous FIFO with combinational read data. Pointers carry
//               one extra wrap bit to tell full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from pre-edge pointers, so a push while full is dropped
    // even if a pop happens on the same edge.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the queue
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/picorv32_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_uart_tx
// Description : Memory-mapped 8N1 UART transmitter on the picorv32 native bus.
//               DATA pushes into a TX FIFO, STATUS reports FIFO/line state,
//               DIV sets the bit time in clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_uart_tx
    import picorv32_uart_pkg::*;
#(
    parameter int          CLK_HZ     = 100000000,
    parameter int          BAUD       = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_idle
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

    logic        hit;
    logic        access;
    logic        commit;
    logic [3:0]  reg_off;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [AW:0] fifo_level;
    logic [3:0]  level_sat;
    logic        ovr;
    logic [15:0] div;
    logic [31:0] read_word;
    tx_state_t   state;
    tx_state_t   state_n;
    logic [15:0] baud_cnt;
    logic [15:0] baud_cnt_n;
    logic [15:0] active_div;
    logic [15:0] active_div_n;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_cnt_n;
    logic [7:0]  shreg;
    logic [7:0]  shreg_n;
    logic        tx_q;
    logic        tx_n;
    logic        unused_bits;

    // Address decode: the acknowledge is one registered pulse per request and
    // register side effects commit on the edge that ends the ready cycle.
    assign hit         = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign access      = mem_valid && hit && !mem_ready;
    assign commit      = mem_ready && mem_valid && hit;
    assign reg_off     = {mem_addr[3:2], 2'b00};
    assign fifo_push   = commit && (reg_off == UART_DATA) && mem_wstrb[0];
    assign unused_bits = &{1'b0, mem_addr[1:0], mem_wdata[31:16]};

    assign level_sat = (32'(fifo_level) > 32'd15) ? 4'hF : 4'(fifo_level);
    assign tx_idle   = fifo_empty && (state == ST_IDLE);
    assign uart_tx   = tx_q;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (mem_wdata[7:0]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // Read mux; unmapped offsets and DATA read back as zero
    always_comb begin
        read_word = 32'b0;
        case (reg_off)
            UART_STATUS: begin
                read_word[STAT_FULL]                     = fifo_full;
                read_word[STAT_IDLE]                     = tx_idle;
                read_word[STAT_OVR]                      = ovr;
                read_word[STAT_LVL_LSB+3:STAT_LVL_LSB]   = level_sat;
            end
            UART_DIV: read_word = {16'b0, div};
            default:  read_word = 32'b0;
        endcase
    end

    // Bus acknowledge and read data; rdata is held at zero outside ready
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'b0;
        end else begin
            mem_ready <= access;
            mem_rdata <= (access && (mem_wstrb == 4'b0)) ? read_word : 32'b0;
        end
    end

    // Control registers: sticky overrun flag and programmable divisor
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovr <= 1'b0;
            div <= DIV_RESET;
        end else begin
            if (fifo_push && fifo_full) begin
                ovr <= 1'b1;
            end else if (commit && (reg_off == UART_STATUS) && mem_wstrb[0] && mem_wdata[STAT_OVR]) begin
                ovr <= 1'b0;
            end
            if (commit && (reg_off == UART_DIV) && (mem_wstrb[1:0] == 2'b11)) begin
                div <= clamp_div(mem_wdata[15:0]);
            end
        end
    end

    // Serialiser state register; the line output is registered to stay glitch-free
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            baud_cnt   <= 16'b0;
            bit_cnt    <= 3'b0;
            shreg      <= 8'b0;
            active_div <= DIV_RESET;
            tx_q       <= 1'b1;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            active_div <= active_div_n;
            tx_q       <= tx_n;
        end
    end

    // Serialiser next state: each bit lasts active_div cycles (count active_div-1 to 0)
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        active_div_n = active_div;
        tx_n         = tx_q;
        fifo_pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shreg_n      = fifo_dout;
                    active_div_n = div;
                    baud_cnt_n   = div - 16'd1;
                    state_n      = ST_START;
                    tx_n         = 1'b0;
                end
            end
            ST_START: begin
                if (baud_cnt == 16'd0) begin
                    state_n    = ST_DATA;
                    baud_cnt_n = active_div - 16'd1;
                    bit_cnt_n  = 3'd0;
                    tx_n       = shreg[0];
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_n = active_div - 16'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_cnt == 16'd0) begin
                    if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        shreg_n      = fifo_dout;
                        active_div_n = div;
                        baud_cnt_n   = div - 16'd1;
                        state_n      = ST_START;
                        tx_n         = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_picorv32_uart_tx
// Description : Scoreboard bench for picorv32_uart_tx. Bus requests queue their
//               expected read data; a bus monitor checks each acknowledge and a
//               line monitor decodes frames against a queue of expected bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_uart_tx;
    import picorv32_uart_pkg::*;

    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam int          BIT_DIV = 4;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr  = 32'b0;
    logic [31:0] mem_wdata = 32'b0;
    logic [3:0]  mem_wstrb = 4'b0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_idle;

    int tests   = 0;
    int fails   = 0;
    int ack_cnt = 0;
    logic mon_en = 1'b0;

    typedef struct packed {
        logic        chk;
        logic [31:0] addr;
        logic [31:0] exp;
    } exp_t;

    exp_t       bus_q[$];
    logic [7:0] byte_q[$];

    picorv32_uart_tx #(
        .CLK_HZ     (100000000),
        .BAUD       (115200),
        .BASE_ADDR  (32'h1000_0000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx),
        .tx_idle   (tx_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Frame bit k of an 8N1 frame: start, eight data bits LSB first, stop
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return d[idx-1];
    endfunction

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic chk, input logic [31:0] exp);
        exp_t ent;
        int   n;
        ent.chk  = chk;
        ent.addr = addr;
        ent.exp  = exp;
        bus_q.push_back(ent);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mem_ready && n < 20);
        if (!mem_ready) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: no ready for 0x%08h in 20 cycles, expected one", addr);
            void'(bus_q.pop_back());
        end else begin
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [3:0] strb);
        bus_xfer(BASE | 32'(off), data, strb, 1'b0, 32'b0);
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] exp);
        bus_xfer(BASE | 32'(off), 32'b0, 4'b0, 1'b1, exp);
    endtask

    task automatic miss_read(input logic [31:0] addr);
        logic        seen;
        logic [31:0] acc_rd;
        seen   = 1'b0;
        acc_rd = 32'b0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = 4'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen   = seen | mem_ready;
            acc_rd = acc_rd | mem_rdata;
        end
        mem_valid = 1'b0;
        check("miss_ready", 32'(seen), 32'd0);
        check("miss_rdata", acc_rd, 32'd0);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!tx_idle && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", 32'(tx_idle), 32'd1);
    endtask

    // Bus monitor: every acknowledge consumes one expectation
    initial begin : bus_mon
        exp_t e;
        logic prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                ack_cnt++;
                check("ready_back_to_back", 32'(prev_ready), 32'd0);
                if (bus_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: ready at 0x%08h, expected none", mem_addr);
                end else begin
                    e = bus_q.pop_front();
                    if (e.chk) check($sformatf("rdata@%08h", e.addr), mem_rdata, e.exp);
                end
            end
            prev_ready = mem_ready;
        end
    end

    // Line monitor: samples each bit 1.5 cycles into its BIT_DIV-cycle slot
    initial begin : uart_mon
        logic [7:0] b;
        logic [7:0] e8;
        b = 8'b0;
        forever begin
            @(negedge clk);
            if (mon_en && resetn && uart_tx == 1'b0) begin
                @(negedge clk);
                check("uart_start", 32'(uart_tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_DIV) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BIT_DIV) @(negedge clk);
                check("uart_stop", 32'(uart_tx), 32'd1);
                if (byte_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got 0x%02h, expected no frame", b);
                end else begin
                    e8 = byte_q.pop_front();
                    check("uart_byte", 32'(b), 32'(e8));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int wave_bad;
        int acks0;

        // Reset defaults
        repeat (5) @(posedge clk);
        #1;
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_tx", 32'(uart_tx), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("idle_tx", 32'(uart_tx), 32'd1);
        check("idle_flag", 32'(tx_idle), 32'd1);
        check("idle_rdata", mem_rdata, 32'd0);
        rd(UART_STATUS, 32'h2);
        rd(UART_DIV, 32'd868);

        // Single byte 0x55 at DIV=4, exact waveform
        mon_en = 1'b1;
        wr(UART_DIV, 32'd4, 4'b0011);
        byte_q.push_back(8'h55);
        wr(UART_DATA, 32'h55, 4'b0001);
        check("tx_before_start", 32'(uart_tx), 32'd1);
        wave_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (uart_tx !== frame_bit(8'h55, k / 4)) wave_bad++;
            if (k == 39) check("busy_in_stop", 32'(tx_idle), 32'd0);
        end
        check("frame55_wave_errs", 32'(wave_bad), 32'd0);
        @(posedge clk); #1;
        check("idle_after_40", 32'(tx_idle), 32'd1);

        // Overflow: ten writes, first pops at once, eight queue, last dropped
        for (int i = 0; i < 9; i++) byte_q.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) wr(UART_DATA, 32'hA0 + 32'(i), 4'b0001);
        rd(UART_STATUS, 32'h85);
        wr(UART_STATUS, 32'h4, 4'b0001);
        rd(UART_STATUS, 32'h81);
        wait_idle(450);
        rd(UART_STATUS, 32'h2);

        // Back-to-back 0x00 then 0xFF: 80 cycles, no idle gap
        byte_q.push_back(8'h00);
        byte_q.push_back(8'hFF);
        wr(UART_DATA, 32'h00, 4'b0001);
        wr(UART_DATA, 32'hFF, 4'b0001);
        check("b2b_k1_low", 32'(uart_tx), 32'd0);
        wave_bad = 0;
        for (int k = 2; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k < 80 && tx_idle) wave_bad++;
            if (k == 39) check("b2b_stop1", 32'(uart_tx), 32'd1);
            if (k == 40) check("b2b_start2", 32'(uart_tx), 32'd0);
        end
        check("b2b_idle_gaps", 32'(wave_bad), 32'd0);
        check("b2b_idle_at_80", 32'(tx_idle), 32'd1);

        // Decode
        miss_read(32'h1000_0010);
        rd(4'hC, 32'd0);
        wr(4'hC, 32'hFFFF_FFFF, 4'b1111);
        rd(UART_DIV, 32'd4);

        // Ack rules with random gaps, divisor clamp, partial strobe ignored
        acks0 = ack_cnt;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            rd(UART_DIV, 32'd4);
        end
        check("ack_count", 32'(ack_cnt - acks0), 32'd6);
        wr(UART_DIV, 32'd1, 4'b0011);
        rd(UART_DIV, 32'd2);
        wr(UART_DIV, 32'd16, 4'b0001);
        rd(UART_DIV, 32'd2);
        wr(UART_DIV, 32'd4, 4'b0011);

        // Reset mid-frame during data bit 3 of 0xF0 with a second byte queued
        mon_en = 1'b0;
        wr(UART_DATA, 32'hF0, 4'b0001);
        wr(UART_DATA, 32'h5A, 4'b0001);
        for (int k = 2; k <= 17; k++) begin
            @(posedge clk); #1;
        end
        check("bit3_before_reset", 32'(uart_tx), 32'd0);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("rst_tx_high", 32'(uart_tx), 32'd1);
        check("rst_idle", 32'(tx_idle), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        rd(UART_STATUS, 32'h2);
        rd(UART_DIV, 32'd868);

        repeat (4) @(posedge clk);
        #1;
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check("byte_q_drained", 32'(byte_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
